tc_irq_ctrl: RTL and testbench

//  Timer0 interrupt controller, directly downstream of the timer/counter core. Latches the overflow and

---
 rtl/tc_pkg.sv | 30 +++
 rtl/tc_irq_prio.sv | 35 +++
 rtl/tc_irq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_tc_irq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared Timer0 constants: bus addresses, flag/mask bit positions, default vectors and the IRQ FSM state type.
package tc_pkg;

    localparam logic [7:0] TC_ADDR_TCCR0A   = 8'h44;
    localparam logic [7:0] TC_ADDR_TCCR0B   = 8'h45;
    localparam logic [7:0] TC_ADDR_TCNT0    = 8'h46;
    localparam logic [7:0] TC_ADDR_OCR0A    = 8'h47;
    localparam logic [7:0] TC_ADDR_OCR0B    = 8'h48;
    localparam logic [7:0] TC_ADDR_TIFR     = 8'h35;
    localparam logic [7:0] TC_ADDR_TIMSK    = 8'h6E;
    localparam logic [7:0] TC_ADDR_LATCNT_L = 8'h6F;
    localparam logic [7:0] TC_ADDR_LATCNT_H = 8'h70;

    // Same bit positions in TIFR (flags) and TIMSK (enables)
    localparam int BIT_TOV  = 0;
    localparam int BIT_OCFA = 1;
    localparam int BIT_OCFB = 2;

    localparam int         TC_VEC_W     = 8;
    localparam logic [7:0] TC_VEC_COMPA = 8'h1C;
    localparam logic [7:0] TC_VEC_COMPB = 8'h1E;
    localparam logic [7:0] TC_VEC_OVF   = 8'h20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/tc_irq_prio.sv
// Fixed-priority encoder for the Timer0 interrupt sources: compare A > compare B > overflow.
module tc_irq_prio
    import tc_pkg::*;
#(
    parameter int               VEC_W     = TC_VEC_W,
    parameter logic [VEC_W-1:0] VEC_COMPA = TC_VEC_COMPA,
    parameter logic [VEC_W-1:0] VEC_COMPB = TC_VEC_COMPB,
    parameter logic [VEC_W-1:0] VEC_OVF   = TC_VEC_OVF
) (
    input  logic [2:0]       pend,
    output logic             valid,
    output logic [1:0]       idx,
    output logic [VEC_W-1:0] vec
);

    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        vec   = '0;
        if (pend[BIT_OCFA]) begin
            valid = 1'b1;
            idx   = 2'(BIT_OCFA);
            vec   = VEC_COMPA;
        end else if (pend[BIT_OCFB]) begin
            valid = 1'b1;
            idx   = 2'(BIT_OCFB);
            vec   = VEC_COMPB;
        end else if (pend[BIT_TOV]) begin
            valid = 1'b1;
            idx   = 2'(BIT_TOV);
            vec   = VEC_OVF;
        end
    end

endmodule

// File: rtl/tc_irq_ctrl.sv
// Timer0 interrupt controller: TIFR/TIMSK registers, priority arbitration and CPU request handshake.
// Optional build macro TC_IRQ_LATCNT_EN adds a request-to-ack latency counter at 8'h6F/8'h70.
//
// state   | meaning
// IDLE    | no request outstanding, waiting for an enabled pending flag with sreg_i=1
// REQ     | irq_req driven with a frozen vector, waiting for irq_ack
// SERVICE | request taken, CPU in ISR, waiting for reti
module tc_irq_ctrl
    import tc_pkg::*;
#(
    parameter logic [7:0]       ADDR_TIMSK = TC_ADDR_TIMSK,
    parameter logic [7:0]       ADDR_TIFR  = TC_ADDR_TIFR,
    parameter int               VEC_W      = TC_VEC_W,
    parameter logic [VEC_W-1:0] VEC_COMPA  = TC_VEC_COMPA,
    parameter logic [VEC_W-1:0] VEC_COMPB  = TC_VEC_COMPB,
    parameter logic [VEC_W-1:0] VEC_OVF    = TC_VEC_OVF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             evt_ovf,
    input  logic             evt_ocma,
    input  logic             evt_ocmb,
    input  logic             sreg_i,
    input  logic             write,
    input  logic             read,
    input  logic [7:0]       addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic             irq_req,
    output logic [VEC_W-1:0] irq_vec,
    input  logic             irq_ack,
    input  logic             reti
);

    irq_state_t       state_q, state_d;
    logic [2:0]       timsk_q, tifr_q, tifr_d;
    logic [2:0]       pend, evt_vec, w1c, ack_clr;
    logic [1:0]       src_q, src_d;
    logic             src_live, ack_take;
    logic             prio_valid;
    logic [1:0]       prio_idx;
    logic [VEC_W-1:0] prio_vec;
    logic             irq_req_d;
    logic [VEC_W-1:0] irq_vec_d;
    logic             rd_hit;
    logic [7:0]       rd_val;
    logic             wr_timsk, wr_tifr;

    assign wr_timsk = write && (addr == ADDR_TIMSK);
    assign wr_tifr  = write && (addr == ADDR_TIFR);
    assign evt_vec  = {evt_ocmb, evt_ocma, evt_ovf};
    assign pend     = tifr_q & timsk_q;
    assign ack_take = (state_q == REQ) && irq_ack;
    assign src_live = tifr_q[src_q] & timsk_q[src_q];
    assign w1c      = wr_tifr ? wdata[2:0] : 3'b000;
    assign ack_clr  = ack_take ? (3'b001 << src_q) : 3'b000;

    // Clears are applied before sets so a same-cycle event always survives
    assign tifr_d   = (tifr_q & ~w1c & ~ack_clr) | evt_vec;

    wire unused_wdata = ^wdata[7:3];

    tc_irq_prio #(
        .VEC_W     (VEC_W),
        .VEC_COMPA (VEC_COMPA),
        .VEC_COMPB (VEC_COMPB),
        .VEC_OVF   (VEC_OVF)
    ) u_prio (
        .pend  (pend),
        .valid (prio_valid),
        .idx   (prio_idx),
        .vec   (prio_vec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timsk_q <= 3'b000;
            tifr_q  <= 3'b000;
        end else begin
            if (wr_timsk) begin
                timsk_q <= wdata[2:0];
            end
            tifr_q <= tifr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= 2'd0;
            irq_req <= 1'b0;
            irq_vec <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            irq_req <= irq_req_d;
            irq_vec <= irq_vec_d;
        end
    end

    // An ack in the same cycle as a collapsing source still wins: the CPU saw irq_req=1
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        case (state_q)
            IDLE: begin
                if (sreg_i && prio_valid) begin
                    state_d = REQ;
                    src_d   = prio_idx;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d = SERVICE;
                end else if (!(sreg_i && src_live)) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (reti) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_req_d = 1'b0;
        irq_vec_d = '0;
        if (state_d == REQ) begin
            irq_req_d = 1'b1;
            irq_vec_d = (state_q == IDLE) ? prio_vec : irq_vec;
        end
    end

`ifdef TC_IRQ_LATCNT_EN
    logic [15:0] lat_run_q, lat_cap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_run_q <= 16'h0000;
            lat_cap_q <= 16'h0000;
        end else begin
            if (state_q == IDLE && state_d == REQ) begin
                lat_run_q <= 16'h0000;
            end else if (state_q == REQ && lat_run_q != 16'hFFFF) begin
                lat_run_q <= lat_run_q + 16'd1;
            end
            if (ack_take) begin
                lat_cap_q <= lat_run_q;
            end else if (write && addr == TC_ADDR_LATCNT_L) begin
                lat_cap_q <= 16'h0000;
            end
        end
    end
`endif

    always_comb begin
        rd_hit = 1'b1;
        rd_val = 8'h00;
        if (addr == ADDR_TIMSK) begin
            rd_val = {5'b00000, timsk_q};
        end else if (addr == ADDR_TIFR) begin
            rd_val = {5'b00000, tifr_q};
`ifdef TC_IRQ_LATCNT_EN
        end else if (addr == TC_ADDR_LATCNT_L) begin
            rd_val = lat_cap_q[7:0];
        end else if (addr == TC_ADDR_LATCNT_H) begin
            rd_val = lat_cap_q[15:8];
`endif
        end else begin
            rd_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 8'h00;
        end else if (read && rd_hit) begin
            rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_tc_irq_ctrl.sv
// Self-checking bench for tc_irq_ctrl: directed scenarios then randomized traffic against a reference model.
module tb_tc_irq_ctrl;
    import tc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       evt_ovf, evt_ocma, evt_ocmb, sreg_i;
    logic       write, read, irq_ack, reti;
    logic [7:0] addr, wdata, rdata, irq_vec;
    logic       irq_req;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tc_irq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .evt_ovf  (evt_ovf),
        .evt_ocma (evt_ocma),
        .evt_ocmb (evt_ocmb),
        .sreg_i   (sreg_i),
        .write    (write),
        .read     (read),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq_req  (irq_req),
        .irq_vec  (irq_vec),
        .irq_ack  (irq_ack),
        .reti     (reti)
    );

    // Reference model: mode 0 = nothing outstanding, 1 = request shown to CPU, 2 = CPU inside ISR
    logic [2:0]  m_flags, m_mask;
    int          m_mode, m_src, m_lat;
    logic        m_req;
    logic [7:0]  m_vec, m_rdata;
    logic [15:0] m_latcap;

    task automatic model_reset();
        m_flags = 3'b000; m_mask = 3'b000; m_mode = 0; m_src = 0; m_lat = 0;
        m_req = 1'b0; m_vec = 8'h00; m_rdata = 8'h00; m_latcap = 16'h0000;
    endtask

    function automatic int winner();
        int order [3] = '{1, 2, 0};
        for (int k = 0; k < 3; k++)
            if (m_flags[order[k]] && m_mask[order[k]]) return order[k];
        return -1;
    endfunction

    function automatic logic [7:0] vec_of(int s);
        return (s == 1) ? 8'h1C : (s == 2) ? 8'h1E : 8'h20;
    endfunction

    task automatic model_step();
        logic [2:0] nf;
        int         w;
        logic       live;
        if (read) begin
            if (addr == 8'h6E) m_rdata = {5'b0, m_mask};
            else if (addr == 8'h35) m_rdata = {5'b0, m_flags};
`ifdef TC_IRQ_LATCNT_EN
            else if (addr == 8'h6F) m_rdata = m_latcap[7:0];
            else if (addr == 8'h70) m_rdata = m_latcap[15:8];
`endif
        end
`ifdef TC_IRQ_LATCNT_EN
        if (write && addr == 8'h6F) m_latcap = 16'h0000;
`endif
        nf = m_flags;
        if (write && addr == 8'h35) nf = nf & ~wdata[2:0];
        w    = winner();
        live = sreg_i && m_flags[m_src] && m_mask[m_src];
        case (m_mode)
            0: if (sreg_i && w >= 0) begin
                m_mode = 1; m_src = w; m_req = 1'b1; m_vec = vec_of(w); m_lat = 0;
            end
            1: if (irq_ack) begin
                m_mode = 2; m_req = 1'b0; nf[m_src] = 1'b0; m_latcap = 16'(m_lat);
            end else if (!live) begin
                m_mode = 0; m_req = 1'b0;
            end else if (m_lat < 65535) begin
                m_lat++;
            end
            default: if (reti) m_mode = 0;
        endcase
        nf = nf | {evt_ocmb, evt_ocma, evt_ovf};
        if (write && addr == 8'h6E) m_mask = wdata[2:0];
        m_flags = nf;
    endtask

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_pulses();
        evt_ovf = 0; evt_ocma = 0; evt_ocmb = 0; write = 0; read = 0; irq_ack = 0; reti = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("irq_req", 16'(irq_req), 16'(m_req));
        if (m_req) check("irq_vec", 16'(irq_vec), 16'(m_vec));
        check("rdata", 16'(rdata), 16'(m_rdata));
        clear_pulses();
    endtask

    task automatic wr(logic [7:0] a, logic [7:0] d);
        write = 1; addr = a; wdata = d;
        tick();
    endtask

    task automatic rd(logic [7:0] a);
        read = 1; addr = a;
        tick();
    endtask

    task automatic wait_req();
        for (int i = 0; i < 12 && !irq_req; i++) tick();
        check("wait_req", 16'(irq_req), 16'd1);
    endtask

    logic [7:0] exp_order [3] = '{8'h1C, 8'h1E, 8'h20};
    logic [7:0] addr_pool [5] = '{8'h6E, 8'h35, 8'h6F, 8'h70, 8'h47};

    initial begin
        clear_pulses();
        sreg_i = 0; addr = 8'h00; wdata = 8'h00;
        rst = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 16'(irq_req), 16'd0);
        check("rst_vec", 16'(irq_vec), 16'd0);
        check("rst_rdata", 16'(rdata), 16'd0);
        @(negedge clk) rst = 0;

        // 1: single compare-A request, latency, ack and reti
        wr(8'h6E, 8'h02);
        sreg_i = 1;
        evt_ocma = 1;
        tick();
        check("t1_lat1", 16'(irq_req), 16'd0);
        tick();
        check("t1_req", 16'(irq_req), 16'd1);
        check("t1_vec", 16'(irq_vec), 16'h1C);
        rd(8'h35);
        check("t1_tifr", 16'(rdata), 16'h02);
        irq_ack = 1;
        tick();
        check("t1_ack", 16'(irq_req), 16'd0);
        rd(8'h35);
        check("t1_tifr_clr", 16'(rdata), 16'h00);
        reti = 1;
        tick();

        // 2: all three events together, served in priority order
        wr(8'h6E, 8'h07);
        evt_ovf = 1; evt_ocma = 1; evt_ocmb = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            wait_req();
            check("t2_vec", 16'(irq_vec), 16'(exp_order[k]));
            irq_ack = 1;
            tick();
            tick();
            check("t2_service", 16'(irq_req), 16'd0);
            reti = 1;
            tick();
        end

        // 3: sreg_i gating and withdrawal before ack
        sreg_i = 0;
        wr(8'h6E, 8'h01);
        evt_ovf = 1;
        tick();
        tick(); tick();
        check("t3_gated", 16'(irq_req), 16'd0);
        sreg_i = 1;
        tick();
        check("t3_req", 16'(irq_req), 16'd1);
        check("t3_vec", 16'(irq_vec), 16'h20);
        sreg_i = 0;
        tick();
        check("t3_drop", 16'(irq_req), 16'd0);
        rd(8'h35);
        check("t3_tifr", 16'(rdata), 16'h01);
        wr(8'h35, 8'h01);

        // 4: event beats same-cycle W1C
        evt_ocma = 1;
        wr(8'h35, 8'h02);
        rd(8'h35);
        check("t4_set_wins", 16'(rdata), 16'h02);
        wr(8'h35, 8'h02);
        rd(8'h35);
        check("t4_w1c", 16'(rdata), 16'h00);

        // 6: latency capture, or unmapped addresses in the default build
`ifdef TC_IRQ_LATCNT_EN
        wr(8'h6E, 8'h02);
        sreg_i = 1;
        evt_ocma = 1;
        tick();
        wait_req();
        repeat (5) tick();
        irq_ack = 1;
        tick();
        rd(8'h6F);
        check("t6_lat_lo", 16'(rdata), 16'h05);
        rd(8'h70);
        check("t6_lat_hi", 16'(rdata), 16'h00);
        reti = 1;
        tick();
`else
        rd(8'h35);
        rd(8'h6F);
        check("t6_unmapped", 16'(rdata), 16'h00);
`endif

        // 5: asynchronous reset while requesting
        wr(8'h6E, 8'h01);
        sreg_i = 1;
        evt_ovf = 1;
        tick();
        wait_req();
        #2 rst = 1;
        #1;
        check("t5_req", 16'(irq_req), 16'd0);
        check("t5_vec", 16'(irq_vec), 16'd0);
        model_reset();
        @(negedge clk) rst = 0;
        rd(8'h6E);
        check("t5_timsk", 16'(rdata), 16'h00);
        rd(8'h35);
        check("t5_tifr", 16'(rdata), 16'h00);
        tick();
        check("t5_idle", 16'(irq_req), 16'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            evt_ovf  = ($urandom_range(0, 9) == 0);
            evt_ocma = ($urandom_range(0, 9) == 0);
            evt_ocmb = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) sreg_i = ~sreg_i;
            irq_ack = ($urandom_range(0, 3) == 0);
            reti    = ($urandom_range(0, 5) == 0);
            addr    = addr_pool[$urandom_range(0, 4)];
            wdata   = 8'($urandom);
            write   = ($urandom_range(0, 5) == 0);
            read    = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
